// File: rtl/alu_pkg.sv
// Shared ALU constants: opcode map and the status-flag bit ordering.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    // RPN ALU operation selector codes. Only ADD and SUB touch the carry,
    // borrow and overflow flags; everything else is a logic/shift op.
    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SUB = 1;
    localparam int unsigned OP_AND = 2;
    localparam int unsigned OP_OR  = 3;
    localparam int unsigned OP_XOR = 4;
    localparam int unsigned OP_NOT = 5;
    localparam int unsigned OP_SHL = 6;
    localparam int unsigned OP_SHR = 7;

    // Flag vector ordering seen by the display logic: {C, B, Z, N, V}.
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned FLAG_C = 4;
    localparam int unsigned FLAG_B = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 0;

    // Packed so that bit positions match the FLAG_* indices above.
    typedef struct packed {
        logic c;
        logic b;
        logic z;
        logic n;
        logic v;
    } flags_t;

    // An "event" is any arithmetic exception: carry, borrow or overflow.
    function automatic logic flags_evt(input flags_t f);
        return f.c | f.b | f.v;
    endfunction

endpackage

// File: rtl/alu_flag_reg_if.sv
// Bundle between the ALU datapath (master) and the flag register (slave).
// Latency: n/a (wires only).
// Backpressure: none; the flag unit accepts every op_valid cycle.
//
// master drives: op_valid, sel, a_msb, b_msb, result, cout, bout, flag_clr
// slave drives : flag_valid, carry, borrow, zero, neg, ovf, sticky_err, evt_count
interface alu_flag_reg_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3,
    parameter int CNT_W = 4
) ();
    logic             op_valid;
    logic [SEL_W-1:0] sel;
    logic             a_msb;
    logic             b_msb;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             bout;
    logic             flag_clr;

    logic             flag_valid;
    logic             carry;
    logic             borrow;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             sticky_err;
    logic [CNT_W-1:0] evt_count;

    modport master (
        output op_valid, sel, a_msb, b_msb, result, cout, bout, flag_clr,
        input  flag_valid, carry, borrow, zero, neg, ovf, sticky_err, evt_count
    );

    modport slave (
        input  op_valid, sel, a_msb, b_msb, result, cout, bout, flag_clr,
        output flag_valid, carry, borrow, zero, neg, ovf, sticky_err, evt_count
    );
endinterface

// File: rtl/alu_flag_calc.sv
// Next-flag terms {C,B,Z,N,V} and event bit from one ALU result.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
//
// Ports: sel/a_msb/b_msb/result/cout/bout in; flags (flags_t) and evt out.
module alu_flag_calc
    import alu_pkg::*;
#(
    parameter int          WIDTH  = 8,
    parameter int          SEL_W  = 3,
    parameter int unsigned OP_ADD = alu_pkg::OP_ADD,
    parameter int unsigned OP_SUB = alu_pkg::OP_SUB
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic [WIDTH-1:0] result,
    input  logic             cout,
    input  logic             bout,
    output flags_t           flags,
    output logic             evt
);
    localparam logic [SEL_W-1:0] SEL_ADD = SEL_W'(OP_ADD);
    localparam logic [SEL_W-1:0] SEL_SUB = SEL_W'(OP_SUB);

    logic r_msb;
    assign r_msb = result[WIDTH-1];

    always_comb begin
        flags   = '0;
        flags.z = (result == '0);
        flags.n = r_msb;
        if (sel == SEL_ADD) begin
            flags.c = cout;
            // Like-signed operands producing an opposite-signed sum.
            flags.v = (a_msb == b_msb) && (r_msb != a_msb);
        end else if (sel == SEL_SUB) begin
            flags.b = bout;
            // Unlike-signed operands where the difference takes B's sign.
            flags.v = (a_msb != b_msb) && (r_msb != a_msb);
        end
    end

    assign evt = flags_evt(flags);

endmodule

// File: rtl/alu_flag_reg.sv
// Registered ALU status flags plus sticky error and saturating event counter.
// Latency: one cycle; an op accepted at edge k is visible right after edge k.
// Backpressure: none; every op_valid cycle is accepted, idle cycles hold state.
//
// Ports: clk, rst (sync, active-high); bus (alu_flag_reg_if.slave) carries the
// sampled ALU op inputs, flag_clr, and all registered flag/counter outputs.
module alu_flag_reg
    import alu_pkg::*;
#(
    parameter int          WIDTH  = 8,
    parameter int          SEL_W  = 3,
    parameter int unsigned OP_ADD = alu_pkg::OP_ADD,
    parameter int unsigned OP_SUB = alu_pkg::OP_SUB,
    parameter int          CNT_W  = 4
) (
    input  logic            clk,
    input  logic            rst,
    alu_flag_reg_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    flags_t           nxt_flags;
    logic             nxt_evt;

    flags_t           flags_q;
    logic             valid_q;
    logic             sticky_q;
    logic [CNT_W-1:0] cnt_q;

    alu_flag_calc #(
        .WIDTH  (WIDTH),
        .SEL_W  (SEL_W),
        .OP_ADD (OP_ADD),
        .OP_SUB (OP_SUB)
    ) u_calc (
        .sel    (bus.sel),
        .a_msb  (bus.a_msb),
        .b_msb  (bus.b_msb),
        .result (bus.result),
        .cout   (bus.cout),
        .bout   (bus.bout),
        .flags  (nxt_flags),
        .evt    (nxt_evt)
    );

    // Priority: rst > op_valid (with or without flag_clr) > flag_clr alone.
    // All op-side inputs are only looked at under op_valid, so junk on them
    // during idle cycles never reaches the registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q  <= '0;
            valid_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else if (bus.op_valid) begin
            flags_q <= nxt_flags;
            valid_q <= 1'b1;
            if (bus.flag_clr) begin
                // Clear and accept together: history dropped, new op kept.
                sticky_q <= nxt_evt;
                cnt_q    <= nxt_evt ? CNT_ONE : '0;
            end else begin
                sticky_q <= sticky_q | nxt_evt;
                if (nxt_evt && (cnt_q != CNT_MAX)) begin
                    cnt_q <= cnt_q + CNT_ONE;
                end
            end
        end else if (bus.flag_clr) begin
            flags_q  <= '0;
            valid_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end
    end

    assign bus.flag_valid = valid_q;
    assign bus.carry      = flags_q.c;
    assign bus.borrow     = flags_q.b;
    assign bus.zero       = flags_q.z;
    assign bus.neg        = flags_q.n;
    assign bus.ovf        = flags_q.v;
    assign bus.sticky_err = sticky_q;
    assign bus.evt_count  = cnt_q;

endmodule

// File: tb/tb_alu_flag_reg.sv
// Directed bench for alu_flag_reg (WIDTH=8, CNT_W=2 to reach saturation fast).
// Latency: checks one cycle after each applied vector.
// Backpressure: none; a vector is applied every cycle.
module tb_alu_flag_reg;

    localparam int WIDTH = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    alu_flag_reg_if #(.WIDTH(WIDTH), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

    alu_flag_reg #(
        .WIDTH  (WIDTH),
        .SEL_W  (SEL_W),
        .OP_ADD (0),
        .OP_SUB (1),
        .CNT_W  (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference state kept as plain integers/bits.
    bit m_valid, m_c, m_b, m_z, m_n, m_v, m_sticky;
    int m_cnt;

    // Apply the architectural rules of one clock edge to the reference state.
    task automatic model_step(input bit r, input bit v, input bit clr, input int s,
                              input bit am, input bit bm, input int res,
                              input bit co, input bit bo);
        bit c, b, z, n, ov, e, rs;
        if (r) begin
            {m_valid, m_c, m_b, m_z, m_n, m_v, m_sticky} = '0;
            m_cnt = 0;
        end else if (v) begin
            rs = ((res >> (WIDTH - 1)) & 1) != 0;
            c  = (s == 0) ? co : 1'b0;
            b  = (s == 1) ? bo : 1'b0;
            z  = (res % (1 << WIDTH)) == 0;
            n  = rs;
            if (s == 0)      ov = (am == bm) && (rs != am);
            else if (s == 1) ov = (am != bm) && (rs != am);
            else             ov = 1'b0;
            e = c || b || ov;
            {m_c, m_b, m_z, m_n, m_v} = {c, b, z, n, ov};
            m_valid = 1'b1;
            if (clr) begin
                m_sticky = e;
                m_cnt    = e ? 1 : 0;
            end else begin
                m_sticky = m_sticky | e;
                if (e && m_cnt < CMAX) m_cnt = m_cnt + 1;
            end
        end else if (clr) begin
            {m_valid, m_c, m_b, m_z, m_n, m_v, m_sticky} = '0;
            m_cnt = 0;
        end
    endtask

    // Full-output comparison against the reference every checked cycle.
    logic [6+CNT_W:0] act_v, exp_v;
    always @(negedge clk) begin
        if (chk_en) begin
            act_v = {bus.flag_valid, bus.carry, bus.borrow, bus.zero, bus.neg,
                     bus.ovf, bus.sticky_err, bus.evt_count};
            exp_v = {m_valid, m_c, m_b, m_z, m_n, m_v, m_sticky, CNT_W'(m_cnt)};
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL model_cmp t=%0t got {vld,C,B,Z,N,V,stk,cnt}=%b want %b",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Drive one vector, clock it, advance the model, return at the negedge.
    task automatic step(input bit r, input bit v, input bit clr, input int s,
                        input bit am, input bit bm, input int res,
                        input bit co, input bit bo);
        rst          = r;
        bus.op_valid = v;
        bus.flag_clr = clr;
        bus.sel      = s[SEL_W-1:0];
        bus.a_msb    = am;
        bus.b_msb    = bm;
        bus.result   = res[WIDTH-1:0];
        bus.cout     = co;
        bus.bout     = bo;
        @(posedge clk);
        #1;
        model_step(r, v, clr, s, am, bm, res, co, bo);
        @(negedge clk);
    endtask

    // Idle cycle with junk on every ignored input.
    task automatic idle();
        step(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        {m_valid, m_c, m_b, m_z, m_n, m_v, m_sticky} = '0;
        m_cnt  = 0;
        chk_en = 1'b1;

        // Reset with an op presented: nothing may load.
        step(1, 1, 0, 0, 0, 0, 8'h80, 1, 1);
        chk("rst_valid", int'(bus.flag_valid), 0);
        chk("rst_cnt",   int'(bus.evt_count), 0);
        step(1, 1, 1, 1, 1, 0, 8'h00, 1, 1);
        for (int i = 0; i < 2; i++) idle();
        chk("rst_hold_ovf", int'(bus.ovf), 0);

        // ADD overflow into negative.
        step(0, 1, 0, 0, 0, 0, 8'h80, 0, 0);
        chk("add1_ovf",   int'(bus.ovf), 1);
        chk("add1_neg",   int'(bus.neg), 1);
        chk("add1_carry", int'(bus.carry), 0);
        chk("add1_stk",   int'(bus.sticky_err), 1);
        chk("add1_cnt",   int'(bus.evt_count), 1);
        // ADD of two negatives wrapping to zero with carry.
        step(0, 1, 0, 0, 1, 1, 8'h00, 1, 0);
        chk("add2_carry", int'(bus.carry), 1);
        chk("add2_zero",  int'(bus.zero), 1);
        chk("add2_ovf",   int'(bus.ovf), 1);
        chk("add2_cnt",   int'(bus.evt_count), 2);

        // SUB with borrow, no overflow.
        step(0, 1, 0, 1, 0, 0, 8'hFF, 0, 1);
        chk("sub_borrow", int'(bus.borrow), 1);
        chk("sub_neg",    int'(bus.neg), 1);
        chk("sub_ovf",    int'(bus.ovf), 0);
        chk("sub_carry",  int'(bus.carry), 0);
        // SUB overflow: +ve minus -ve giving -ve.
        step(0, 1, 0, 1, 0, 1, 8'h90, 0, 1);
        chk("sub2_ovf", int'(bus.ovf), 1);
        // Logic op ignores cout/bout.
        step(0, 1, 0, 2, 0, 1, 8'h3C, 1, 1);
        chk("log_carry",  int'(bus.carry), 0);
        chk("log_borrow", int'(bus.borrow), 0);
        chk("log_ovf",    int'(bus.ovf), 0);
        chk("log_stk",    int'(bus.sticky_err), 1);

        // Saturation.
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("clr_valid", int'(bus.flag_valid), 0);
        chk("clr_stk",   int'(bus.sticky_err), 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 0, 0, 8'h05, 1, 0);
            chk($sformatf("sat_cnt%0d", i), int'(bus.evt_count), (i < 3) ? i + 1 : 3);
        end
        for (int i = 0; i < 3; i++) idle();
        chk("sat_hold_cnt",   int'(bus.evt_count), 3);
        chk("sat_hold_carry", int'(bus.carry), 1);

        // Clear together with an op.
        step(0, 1, 1, 0, 0, 0, 8'h05, 1, 0);
        chk("clrop_carry", int'(bus.carry), 1);
        chk("clrop_zero",  int'(bus.zero), 0);
        chk("clrop_stk",   int'(bus.sticky_err), 1);
        chk("clrop_cnt",   int'(bus.evt_count), 1);
        chk("clrop_valid", int'(bus.flag_valid), 1);
        step(0, 1, 1, 3, 1, 0, 8'h21, 1, 1);
        chk("clrne_stk",   int'(bus.sticky_err), 0);
        chk("clrne_cnt",   int'(bus.evt_count), 0);
        chk("clrne_valid", int'(bus.flag_valid), 1);

        // Reset beats an event op at evt_count=2.
        step(0, 1, 0, 0, 0, 0, 8'h05, 1, 0);
        step(0, 1, 0, 1, 0, 0, 8'h01, 0, 1);
        chk("pre_rst_cnt", int'(bus.evt_count), 2);
        step(1, 1, 0, 0, 0, 0, 8'h80, 1, 0);
        chk("midrst_cnt",   int'(bus.evt_count), 0);
        chk("midrst_valid", int'(bus.flag_valid), 0);
        chk("midrst_carry", int'(bus.carry), 0);
        idle();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_flag_reg.md
Name: alu_flag_reg

Overview:
- Registered status-flag unit for the RPN ALU; successor to the combinational carry/borrow flag.
- Samples the ALU result and carry/borrow on each accepted operation and registers five flags: C, B, Z, N, V.
- Adds a sticky error flag and a saturating event counter, driven to the LED/display layer.
- Sits between the ALU datapath and the display logic; parametrised in result width, selector width and counter width.

Parameters:
- WIDTH, 8, ALU result width in bits (>=2).
- SEL_W, 3, operation selector width (>=1).
- OP_ADD, 0, selector code for addition.
- OP_SUB, 1, selector code for subtraction.
- CNT_W, 4, event counter width (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  ALU operation complete this cycle; inputs below are sampled only when high.
- sel  in  SEL_W  operation selector.
- a_msb  in  1  sign bit of operand A.
- b_msb  in  1  sign bit of operand B.
- result  in  WIDTH  ALU result.
- cout  in  1  adder carry out.
- bout  in  1  subtractor borrow out.
- flag_clr  in  1  clear flags, sticky and counter.
- flag_valid  out  1  flags reflect at least one accepted operation since last reset/clear.
- carry  out  1  registered C.
- borrow  out  1  registered B.
- zero  out  1  registered Z.
- neg  out  1  registered N.
- ovf  out  1  registered signed overflow V.
- sticky_err  out  1  OR of C|B|V over all ops since last reset/clear.
- evt_count  out  CNT_W  number of ops raising C|B|V, saturating.

Behaviour:
- Reset: one clock and one reset, synchronous and active-high (clk, rst); rst high at a rising edge forces all outputs to 0 (flag_valid=0, evt_count=0). Reset overrides every other input, including mid-sequence.
- Latency: flags are registered; values for an op accepted at edge k are visible after edge k.
- op_valid low: all registers hold.
- Combinational next-flag terms from sampled inputs:
  - C = cout when sel==OP_ADD, else 0.
  - B = bout when sel==OP_SUB, else 0.
  - Z = (result == 0) for every sel.
  - N = result[WIDTH-1] for every sel.
  - V (ADD) = (a_msb == b_msb) & (result[WIDTH-1] != a_msb).
  - V (SUB) = (a_msb != b_msb) & (result[WIDTH-1] != a_msb).
  - V = 0 for any other sel.
  - evt = C | B | V.
- Accepted op (op_valid=1, flag_clr=0):
  - Load C, B, Z, N, V; flag_valid <= 1.
  - sticky_err <= sticky_err | evt.
  - evt_count <= evt_count + 1 if evt and evt_count < 2^CNT_W-1; hold at saturation, never wraps.
- flag_clr=1, op_valid=0: C, B, Z, N, V, sticky_err, evt_count and flag_valid all go to 0.
- flag_clr=1 and op_valid=1 in the same cycle: history is discarded, new op is loaded.
  - Flags load the new op's values; flag_valid <= 1.
  - sticky_err <= evt.
  - evt_count <= evt ? 1 : 0.
- Selector codes other than OP_ADD/OP_SUB are legal logic ops; they never raise C, B or V.
- X on ignored inputs while op_valid=0 must not propagate to any output.

Decomposition:
- Shared package/include alu_pkg holds the opcode constants (OP_ADD, OP_SUB and the remaining ALU op codes) and the flag bit ordering {C, B, Z, N, V} used by the display logic.
- One natural sub-module: alu_flag_calc, purely combinational. It maps sel, a_msb, b_msb, result, cout and bout to C, B, Z, N, V and evt.
- alu_flag_reg holds only the registers, the clear/valid priority logic and the saturating counter.

Test Plan:
- Reset: drive rst=1 with random inputs and op_valid=1 -> all outputs 0 after the edge. Release rst -> outputs stay 0 with op_valid=0.
- ADD, WIDTH=8: sel=0, a_msb=0, b_msb=0, result=8'h80, cout=0 -> ovf=1, neg=1, carry=0, zero=0, sticky_err=1, evt_count=1. Then result=8'h00, cout=1, a_msb=b_msb=1 -> carry=1, zero=1, ovf=1, evt_count=2.
- SUB: sel=1, bout=1, a_msb=0, b_msb=0, result=8'hFF -> borrow=1, neg=1, ovf=0, carry=0. Then sel=2 (logic op) with cout=1, bout=1 -> carry=borrow=ovf=0, sticky_err stays 1.
- Saturation, CNT_W=2: five consecutive evt ops -> evt_count sequence 1,2,3,3,3. Then op_valid=0 for 3 cycles -> all outputs hold.
- Clear: flag_clr alone -> all outputs 0. flag_clr with op_valid (sel=0, cout=1, result=8'h05) -> carry=1, zero=0, sticky_err=1, evt_count=1, flag_valid=1. flag_clr with a non-event op -> sticky_err=0, evt_count=0.
- Reset mid-sequence: assert rst in the same cycle as an evt op with evt_count=2 -> all outputs 0 next cycle, with no increment.
